gen_gamma_sequencer: RTL and testbench
======================================

// Module: gen_gamma_sequencer
// PURPOSE
//  Controller that sequences one gen_gamma_coder instance. Accepts plain words over a
//  valid/ready handshake and pulses set0 to capture the word and the noise key. Waits a
//  programmable settle time for the xor_extender/adder path, then pulses set1 to capture
//  the mixed data. Presents {nk, md} downstream over a valid/ready handshake.
//  Sits between the upstream data source and the coder; the coder instantiates inside
//  the same top level.
// PARAMETERS
//  SIZE        8   data word width; nk is SIZE bits, md is SIZE+1 bits
//  SETTLE_CYC  2   idle cycles between the set0 and set1 pulses; legal range 1..255
//  CNT_W       16  width of the processed-word counter
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       upstream word valid
//  in_ready   out  1       sequencer can accept a word
//  in_id      in   SIZE    upstream plain word
//  cd_rst_n   out  1       coder reset; equals ~rst (combinational)
//  cd_set0    out  1       coder input/noise-key capture strobe
//  cd_set1    out  1       coder mixed-data capture strobe
//  cd_id      out  SIZE    word presented to coder id; held register
//  cd_nk      in   SIZE    coder noise key
//  cd_md      in   SIZE+1  coder mixed data
//  out_valid  out  1       result valid
//  out_ready  in   1       downstream accepts result
//  out_nk     out  SIZE    result noise key; equals cd_nk (combinational)
//  out_md     out  SIZE+1  result mixed data; equals cd_md (combinational)
//  busy       out  1       high in every state except IDLE
//  word_cnt   out  CNT_W   count of results accepted downstream; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset values (rst=1 at a clk edge): state=IDLE, cd_id=0, settle counter=0,
//  word_cnt=0. All strobes and valids low after the edge.
//  FSM states: IDLE, LOAD, SETTLE, MIX, OUT.
//   IDLE:   in_ready=1. On in_valid, latch in_id into cd_id and go to LOAD.
//   LOAD:   cd_set0=1 for exactly one cycle. Load counter with SETTLE_CYC-1, then go to SETTLE.
//   SETTLE: hold while counter!=0, decrementing each cycle. At 0, go to MIX.
//           SETTLE therefore lasts exactly SETTLE_CYC cycles.
//   MIX:    cd_set1=1 for exactly one cycle, then go to OUT.
//   OUT:    out_valid=1. On out_ready, increment word_cnt and go to IDLE.
//  Strobes are Moore outputs decoded from the state register. At most one strobe is
//  high in any cycle; cd_set0 and cd_set1 are never high together.
//  cd_id changes only on an IDLE accept, so it is stable across the set0 edge.
//  in_ready=0 in every non-IDLE state; no input is accepted while busy.
//  Latency from accept edge to out_valid high: SETTLE_CYC+2 cycles.
//  Minimum word period: SETTLE_CYC+4 cycles.
//  out_nk/out_md stay stable for the whole of OUT: no strobe is issued there.
//  out_valid stays high until out_ready; it never drops without a handshake.
//  Backpressure: the sequencer waits in OUT indefinitely.
//  If out_ready is already high on entry to OUT, the transfer completes in one cycle.
//  Reset mid-operation (any state): return to IDLE next edge; an in-flight word is
//  discarded and word_cnt clears. cd_rst_n asserts, clearing the coder registers.
//  word_cnt wrap: 2^CNT_W-1 + 1 -> 0, with no flag.
// STRUCTURE
//  Shared package gen_gamma_pkg holds:
//   - typedef enum logic [2:0] gg_state_t {IDLE, LOAD, SETTLE, MIX, OUT}
//   - localparam GG_SIZE = 8, the default word width
//   - localparam GG_SETTLE_DEF = 2
//  No sub-module: the FSM, settle counter, id hold register and word counter are all
//  inline. A top-level gen_gamma_top wires this block to gen_gamma_coder.
// TESTING
//  1. Single word: SETTLE_CYC=2, in_id=8'hA5 accepted at cycle 0.
//     -> set0 at cycle 1; set1 at cycle 4; out_valid at cycle 5.
//     -> out_md = nk + 8'hA5 with the 9-bit carry; word_cnt=1.
//  2. Backpressure: out_ready=0 for 10 cycles.
//     -> out_valid held high; out_nk/out_md unchanged; in_ready=0; no strobes.
//  3. Back-to-back: in_valid=1 continuously, ids 1,2,3, out_ready=1.
//     -> accepts spaced exactly 6 cycles apart; word_cnt=3.
//  4. Reset in SETTLE: assert rst for one cycle.
//     -> next cycle IDLE, in_ready=1, busy=0, word_cnt=0, no set1 issued.
//  5. Counter wrap: CNT_W=2, complete 5 words -> word_cnt sequence 1,2,3,0,1.
//  6. SETTLE_CYC=1: in_id=8'hFF, forced nk=8'h01.
//     -> set0 and set1 are 2 cycles apart; out_md=9'h100.

Source files
------------

// File: rtl/gen_gamma_pkg.sv
// Shared types and defaults for the gen_gamma coder sequencing logic.
package gen_gamma_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        MIX    = 3'd3,
        OUT    = 3'd4
    } gg_state_t;

    localparam int GG_SIZE       = 8;
    localparam int GG_SETTLE_DEF = 2;
    localparam int GG_CNT_W      = 16;

endpackage

// File: rtl/gen_gamma_sequencer.sv
// Sequences one gen_gamma_coder: capture word and key (set0), wait for the mix
// path to settle, capture mixed data (set1), then hand {nk, md} downstream.
module gen_gamma_sequencer
    import gen_gamma_pkg::*;
#(
    parameter int SIZE       = GG_SIZE,
    parameter int SETTLE_CYC = GG_SETTLE_DEF,
    parameter int CNT_W      = GG_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_id,
    output logic             cd_rst_n,
    output logic             cd_set0,
    output logic             cd_set1,
    output logic [SIZE-1:0]  cd_id,
    input  logic [SIZE-1:0]  cd_nk,
    input  logic [SIZE:0]    cd_md,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE-1:0]  out_nk,
    output logic [SIZE:0]    out_md,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);

    // Counter is loaded one short because the cycle that sees zero is itself a SETTLE cycle.
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);

    gg_state_t  state;
    logic [7:0] settle_cnt;

    assign cd_rst_n = ~rst;
    assign out_nk   = cd_nk;
    assign out_md   = cd_md;

    // Outputs are registered alongside the state so each equals a decode of the new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cd_id      <= '0;
            settle_cnt <= '0;
            word_cnt   <= '0;
            cd_set0    <= 1'b0;
            cd_set1    <= 1'b0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cd_id    <= in_id;
                        state    <= LOAD;
                        cd_set0  <= 1'b1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    cd_set0    <= 1'b0;
                    settle_cnt <= SETTLE_LD;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt != 8'd0) begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end else begin
                        state   <= MIX;
                        cd_set1 <= 1'b1;
                    end
                end
                MIX: begin
                    cd_set1   <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        word_cnt  <= word_cnt + 1'b1;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cd_set0   <= 1'b0;
                    cd_set1   <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gen_gamma_sequencer.sv
// Bench for gen_gamma_sequencer: two instances (settle 2 / wide counter, settle 1 / 2-bit counter)
// each driving a small behavioural coder; results checked through per-instance scoreboards.
module tb_gen_gamma_sequencer;

    typedef struct {
        logic [7:0] id;
        logic [7:0] key;
        logic [8:0] md;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // instance a: SETTLE_CYC=2, CNT_W=16
    logic        rst_a, in_valid_a, in_ready_a, cd_rst_n_a, cd_set0_a, cd_set1_a;
    logic        out_valid_a, out_ready_a, busy_a;
    logic [7:0]  in_id_a, cd_id_a, cd_nk_a, out_nk_a, key_a, idc_a;
    logic [8:0]  cd_md_a, out_md_a;
    logic [15:0] word_cnt_a;

    // instance b: SETTLE_CYC=1, CNT_W=2
    logic        rst_b, in_valid_b, in_ready_b, cd_rst_n_b, cd_set0_b, cd_set1_b;
    logic        out_valid_b, out_ready_b, busy_b;
    logic [7:0]  in_id_b, cd_id_b, cd_nk_b, out_nk_b, key_b, idc_b;
    logic [8:0]  cd_md_b, out_md_b;
    logic [1:0]  word_cnt_b;

    logic [16:0] q_a[$];
    logic [16:0] q_b[$];
    logic [16:0] ea, eb;

    gen_gamma_sequencer #(.SIZE(8), .SETTLE_CYC(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_id(in_id_a),
        .cd_rst_n(cd_rst_n_a), .cd_set0(cd_set0_a), .cd_set1(cd_set1_a), .cd_id(cd_id_a),
        .cd_nk(cd_nk_a), .cd_md(cd_md_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_nk(out_nk_a), .out_md(out_md_a), .busy(busy_a), .word_cnt(word_cnt_a)
    );

    gen_gamma_sequencer #(.SIZE(8), .SETTLE_CYC(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_id(in_id_b),
        .cd_rst_n(cd_rst_n_b), .cd_set0(cd_set0_b), .cd_set1(cd_set1_b), .cd_id(cd_id_b),
        .cd_nk(cd_nk_b), .cd_md(cd_md_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_nk(out_nk_b), .out_md(out_md_b), .busy(busy_b), .word_cnt(word_cnt_b)
    );

    // Behavioural coder: key and word captured on set0, sum with carry captured on set1.
    always @(posedge clk) begin
        if (!cd_rst_n_a) begin
            cd_nk_a <= '0; idc_a <= '0; cd_md_a <= '0;
        end else begin
            if (cd_set0_a) begin cd_nk_a <= key_a; idc_a <= cd_id_a; end
            if (cd_set1_a) cd_md_a <= {1'b0, cd_nk_a} + {1'b0, idc_a};
        end
    end

    always @(posedge clk) begin
        if (!cd_rst_n_b) begin
            cd_nk_b <= '0; idc_b <= '0; cd_md_b <= '0;
        end else begin
            if (cd_set0_b) begin cd_nk_b <= key_b; idc_b <= cd_id_b; end
            if (cd_set1_b) cd_md_b <= {1'b0, cd_nk_b} + {1'b0, idc_b};
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard pop on each downstream handshake.
    always @(negedge clk) begin
        if (out_valid_a && out_ready_a) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_out", 32'(out_md_a), 32'h1ffff);
            end else begin
                ea = q_a.pop_front();
                chk("a_out_nk", 32'(out_nk_a), 32'(ea[16:9]));
                chk("a_out_md", 32'(out_md_a), 32'(ea[8:0]));
            end
        end
        if (out_valid_b && out_ready_b) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_out", 32'(out_md_b), 32'h1ffff);
            end else begin
                eb = q_b.pop_front();
                chk("b_out_nk", 32'(out_nk_b), 32'(eb[16:9]));
                chk("b_out_md", 32'(out_md_b), 32'(eb[8:0]));
            end
        end
    end

    task automatic send(input bit b, input logic [7:0] id, input logic [7:0] key, input logic [8:0] md);
        int t = 0;
        @(negedge clk);
        while (!(b ? in_ready_b : in_ready_a) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("send_ready_timeout", 32'(t), 32'd0);
        if (b) begin
            in_valid_b = 1'b1; in_id_b = id; key_b = key; q_b.push_back({key, md});
        end else begin
            in_valid_a = 1'b1; in_id_a = id; key_a = key; q_a.push_back({key, md});
        end
        @(posedge clk);
        #1;
        if (b) in_valid_b = 1'b0; else in_valid_a = 1'b0;
    endtask

    task automatic wait_idle(input bit b);
        int t = 0;
        @(negedge clk);
        while (((b ? q_b.size() : q_a.size()) != 0 || (b ? busy_b : busy_a)) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("idle_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit b);
        @(posedge clk);
        #1;
        if (b) rst_b = 1'b1; else rst_a = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        if (b) begin rst_b = 1'b0; q_b.delete(); end
        else   begin rst_a = 1'b0; q_a.delete(); end
    endtask

    vec_t tbl[6];
    logic [5:0] s0_log, s1_log, ov_log, ir_log;
    logic [7:0] snap_nk, snap_id;
    logic [8:0] snap_md;
    logic       bp_ok, rst_ok;
    int         acc[3];
    logic [1:0] wrap_exp[5];

    initial begin
        tbl[0] = '{id: 8'hFF, key: 8'hFF, md: 9'h1FE};
        tbl[1] = '{id: 8'h00, key: 8'h00, md: 9'h000};
        tbl[2] = '{id: 8'h80, key: 8'h80, md: 9'h100};
        tbl[3] = '{id: 8'h01, key: 8'hFE, md: 9'h0FF};
        tbl[4] = '{id: 8'h7F, key: 8'h01, md: 9'h080};
        tbl[5] = '{id: 8'hA5, key: 8'h3C, md: 9'h0E1};
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

        rst_a = 1'b1; rst_b = 1'b1;
        in_valid_a = 1'b0; in_valid_b = 1'b0; in_id_a = '0; in_id_b = '0;
        key_a = '0; key_b = '0; out_ready_a = 1'b1; out_ready_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_cd_rst_n_low", 32'(cd_rst_n_a), 32'd0);
        @(posedge clk);
        #1;
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_strobes", 32'({cd_set0_a, cd_set1_a}), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt_a), 32'd0);
        chk("rst_cd_id", 32'(cd_id_a), 32'd0);
        chk("rst_cd_rst_n_high", 32'(cd_rst_n_a), 32'd1);

        // single word: strobe timing relative to the accept edge
        s0_log = '0; s1_log = '0; ov_log = '0; ir_log = '0;
        send(1'b0, 8'hA5, 8'h6B, 9'h110);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            s0_log[c] = cd_set0_a; s1_log[c] = cd_set1_a;
            ov_log[c] = out_valid_a; ir_log[c] = in_ready_a;
        end
        chk("t1_set0_cycle", 32'(s0_log), 32'b000010);
        chk("t1_set1_cycle", 32'(s1_log), 32'b010000);
        chk("t1_out_valid_cycle", 32'(ov_log), 32'b100000);
        chk("t1_in_ready_low", 32'(ir_log), 32'b000000);
        wait_idle(1'b0);
        chk("t1_word_cnt", 32'(word_cnt_a), 32'd1);

        for (int i = 0; i < 6; i++) begin
            send(1'b0, tbl[i].id, tbl[i].key, tbl[i].md);
            wait_idle(1'b0);
        end
        chk("tbl_word_cnt", 32'(word_cnt_a), 32'd7);

        // backpressure held for 10 cycles while upstream keeps offering a word
        out_ready_a = 1'b0;
        send(1'b0, 8'h5C, 8'h33, 9'h08F);
        begin
            int t = 0;
            @(negedge clk);
            while (!out_valid_a && t < 50) begin @(negedge clk); t++; end
            chk("bp_out_valid_seen", 32'(out_valid_a), 32'd1);
        end
        snap_nk = out_nk_a; snap_md = out_md_a; snap_id = cd_id_a;
        in_valid_a = 1'b1; in_id_a = 8'h99;
        bp_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!out_valid_a || in_ready_a || cd_set0_a || cd_set1_a || !busy_a) bp_ok = 1'b0;
            if (out_nk_a !== snap_nk || out_md_a !== snap_md || cd_id_a !== snap_id) bp_ok = 1'b0;
        end
        chk("bp_hold", 32'(bp_ok), 32'd1);
        chk("bp_cnt_unchanged", 32'(word_cnt_a), 32'd7);
        @(posedge clk);
        #1;
        in_valid_a = 1'b0; out_ready_a = 1'b1;
        wait_idle(1'b0);
        chk("bp_word_cnt", 32'(word_cnt_a), 32'd8);

        // reset while in SETTLE discards the word
        send(1'b0, 8'h11, 8'h22, 9'h033);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        q_a.delete();
        @(negedge clk);
        chk("rs_in_ready", 32'(in_ready_a), 32'd1);
        chk("rs_busy", 32'(busy_a), 32'd0);
        chk("rs_word_cnt", 32'(word_cnt_a), 32'd0);
        rst_ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (cd_set1_a || out_valid_a || cd_set0_a) rst_ok = 1'b0;
            @(negedge clk);
        end
        chk("rs_no_set1", 32'(rst_ok), 32'd1);

        // back-to-back with in_valid held high
        @(posedge clk);
        #1;
        key_a = 8'h10; in_valid_a = 1'b1; in_id_a = 8'd1;
        for (int k = 0; k < 3; k++) begin
            int t = 0;
            @(negedge clk);
            while (!in_ready_a && t < 50) begin @(negedge clk); t++; end
            acc[k] = cyc;
            q_a.push_back({8'h10, 9'(9'd16 + 9'(k + 1))});
            @(posedge clk);
            #1;
            in_id_a = 8'(k + 2);
        end
        in_valid_a = 1'b0;
        wait_idle(1'b0);
        chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'd6);
        chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'd6);
        chk("b2b_word_cnt", 32'(word_cnt_a), 32'd3);

        // SETTLE_CYC=1: set0/set1 two cycles apart, carry out of FF+01
        do_reset(1'b1);
        s0_log = '0; s1_log = '0; ov_log = '0;
        send(1'b1, 8'hFF, 8'h01, 9'h100);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            s0_log[c] = cd_set0_b; s1_log[c] = cd_set1_b; ov_log[c] = out_valid_b;
        end
        chk("s1_set0_cycle", 32'(s0_log), 32'b000010);
        chk("s1_set1_cycle", 32'(s1_log), 32'b001000);
        chk("s1_out_valid_cycle", 32'(ov_log), 32'b010000);
        wait_idle(1'b1);

        // 2-bit counter wraps 3 -> 0
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            send(1'b1, 8'(i * 16), 8'h02, 9'(i * 16 + 2));
            wait_idle(1'b1);
            chk("wrap_word_cnt", 32'(word_cnt_b), 32'(wrap_exp[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
